// File: rtl/stream_mux_n_to_one_pkg.sv
// stream_mux_pkg: shared definitions for the N:1 stream mux.
//   MODE_SEL / MODE_RR : run-time mode encoding on the mode port
//   state_t            : output register occupancy
//   wrap_inc           : index increment with wrap at n
package stream_mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/stream_mux_n_to_one_if.sv
// stream_mux_n_to_one_if: handshake bundle between NUM_CH producers, the mux
// and its single consumer.
//   in_data   NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  NUM_CH        per-channel valid
//   in_ready  NUM_CH        per-channel ready (one-hot or zero)
//   in_last   NUM_CH        end of multi-beat group (only with STREAM_MUX_HOLD_EN)
//   out_data  WIDTH         registered data
//   out_ch    SEL_W         source channel of out_data
//   out_valid 1             output register full
//   out_ready 1             consumer ready
// Modports: slave = mux side, master = producers/consumer side.
interface stream_mux_n_to_one_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
`ifdef STREAM_MUX_HOLD_EN
   logic [NUM_CH-1:0]       in_last;
`endif
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_valid;
   logic                    out_ready;

   modport slave (
`ifdef STREAM_MUX_HOLD_EN
      input  in_last,
`endif
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_ch,
      output out_valid,
      input  out_ready
   );

   modport master (
`ifdef STREAM_MUX_HOLD_EN
      output in_last,
`endif
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_ch,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/stream_mux_n_to_one_rr_arbiter_n.sv
// rr_arbiter_n: combinational round-robin pick. Searches req upward from ptr,
// wrapping to 0; first set bit wins.
//   req       in   NUM_CH  request vector
//   ptr       in   SEL_W   search start index (< NUM_CH)
//   gnt_oh    out  NUM_CH  one-hot grant (zero when no request)
//   gnt_idx   out  SEL_W   granted index
//   gnt_valid out  1       any request granted
module rr_arbiter_n #(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] gnt_oh,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              gnt_valid
);

   always_comb begin
      int cand;
      cand      = 0;
      gnt_oh    = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      for (int off = 0; off < NUM_CH; off++) begin
         cand = (int'(ptr) + off) % NUM_CH;
         if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SEL_W'(cand);
         end
      end
      if (gnt_valid) gnt_oh[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/stream_mux_n_to_one.sv
// stream_mux_n_to_one: NUM_CH x WIDTH-bit valid/ready streams merged onto one
// registered output stream. Explicit select (mode=0) or round-robin (mode=1).
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   mode   in  0 = explicit select, 1 = round-robin
//   sel    in  channel index used when mode=0
//   bus    slave modport of stream_mux_n_to_one_if (channel inputs, output stream)
// Optional macro STREAM_MUX_HOLD_EN: adds bus.in_last and locks the grant to a
// channel from its first beat until a beat with in_last=1 transfers.
//
// state    | meaning
// ST_EMPTY | output register holds nothing, out_valid=0
// ST_FULL  | output register holds a beat, out_valid=1
module stream_mux_n_to_one
   import stream_mux_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   stream_mux_n_to_one_if.slave bus
);

   state_t                  state;
   logic [WIDTH-1:0]        data_q;
   logic [SEL_W-1:0]        ch_q;
   logic [SEL_W-1:0]        rr_ptr;

   logic                    load_en;
   logic [(1<<SEL_W)-1:0]   valid_pad;
   logic                    sel_gv;
   logic [NUM_CH-1:0]       sel_oh;
   logic [NUM_CH-1:0]       rr_oh;
   logic [SEL_W-1:0]        rr_idx;
   logic                    rr_gv;
   logic [NUM_CH-1:0]       g_oh;
   logic [SEL_W-1:0]        g_idx;
   logic                    g_valid;
   logic [WIDTH-1:0]        g_data;
   logic                    xfer_in;
   logic                    xfer_out;

`ifdef STREAM_MUX_HOLD_EN
   logic                    locked;
   logic [SEL_W-1:0]        lock_ch;
`endif

   assign load_en = (state == ST_EMPTY) || bus.out_ready;

   // Padding to a power of two lets an out-of-range sel index safely read 0.
   always_comb begin
      valid_pad = '0;
      valid_pad[NUM_CH-1:0] = bus.in_valid;
   end

   always_comb begin
      sel_oh = '0;
      sel_gv = (int'(sel) < NUM_CH) && valid_pad[sel];
      for (int i = 0; i < NUM_CH; i++) begin
         sel_oh[i] = sel_gv && (sel == SEL_W'(i));
      end
   end

   rr_arbiter_n #(.NUM_CH(NUM_CH)) u_rr_arb (
      .req       (bus.in_valid),
      .ptr       (rr_ptr),
      .gnt_oh    (rr_oh),
      .gnt_idx   (rr_idx),
      .gnt_valid (rr_gv)
   );

   always_comb begin
      if (mode == MODE_SEL) begin
         g_oh    = sel_oh;
         g_idx   = sel;
         g_valid = sel_gv;
      end else begin
         g_oh    = rr_oh;
         g_idx   = rr_idx;
         g_valid = rr_gv;
      end
`ifdef STREAM_MUX_HOLD_EN
      // A locked channel keeps the grant; others wait even if it stalls.
      if (locked) begin
         g_idx   = lock_ch;
         g_valid = valid_pad[lock_ch];
         for (int i = 0; i < NUM_CH; i++) begin
            g_oh[i] = g_valid && (lock_ch == SEL_W'(i));
         end
      end
`endif
   end

   assign g_data       = bus.in_data[int'(g_idx)*WIDTH +: WIDTH];
   assign bus.in_ready = (rst_n && load_en && g_valid) ? g_oh : '0;
   assign xfer_in      = |(bus.in_valid & bus.in_ready);
   assign xfer_out     = (state == ST_FULL) && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_EMPTY;
         data_q  <= '0;
         ch_q    <= '0;
         rr_ptr  <= '0;
`ifdef STREAM_MUX_HOLD_EN
         locked  <= 1'b0;
         lock_ch <= '0;
`endif
      end else begin
         case (state)
            ST_EMPTY: if (xfer_in) state <= ST_FULL;
            ST_FULL:  if (xfer_out && !xfer_in) state <= ST_EMPTY;
            default:  state <= ST_EMPTY;
         endcase
         if (xfer_in) begin
            data_q <= g_data;
            ch_q   <= g_idx;
         end
         if (xfer_in && (mode == MODE_RR)) begin
            rr_ptr <= SEL_W'(wrap_inc(32'(g_idx), NUM_CH));
         end
`ifdef STREAM_MUX_HOLD_EN
         if (xfer_in) begin
            locked  <= !bus.in_last[g_idx];
            lock_ch <= g_idx;
         end
`endif
      end
   end

   assign bus.out_valid = (state == ST_FULL);
   assign bus.out_data  = data_q;
   assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux_n_to_one.sv
module tb_stream_mux_n_to_one;

   logic clk = 1'b0;
   logic rst_n;
   logic mode4;
   logic [1:0] sel4;
   logic mode3;
   logic [1:0] sel3;

   always #5 clk = ~clk;

   stream_mux_n_to_one_if #(.WIDTH(8), .NUM_CH(4)) bus4 ();
   stream_mux_n_to_one_if #(.WIDTH(8), .NUM_CH(3)) bus3 ();

   stream_mux_n_to_one #(.WIDTH(8), .NUM_CH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode4),
      .sel   (sel4),
      .bus   (bus4)
   );

   stream_mux_n_to_one #(.WIDTH(8), .NUM_CH(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode3),
      .sel   (sel3),
      .bus   (bus3)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [9:0] exp_q[$];
   logic [3:0] hold_last = 4'hF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic m,
                        input logic [1:0] s, input logic r);
      bus4.in_valid  = v;
      bus4.in_data   = d;
      mode4          = m;
      sel4           = s;
      bus4.out_ready = r;
`ifdef STREAM_MUX_HOLD_EN
      bus4.in_last   = hold_last;
`endif
   endtask

   // One cycle: drive at negedge, check in_ready, queue the expected output beat.
   task automatic cyc(input string name, input logic [3:0] v, input logic [31:0] d,
                      input logic m, input logic [1:0] s, input logic r,
                      input logic [3:0] exp_rdy, input bit push,
                      input logic [7:0] ed, input logic [1:0] ec);
      @(negedge clk);
      drive(v, d, m, s, r);
      #2;
      chk(name, 32'(bus4.in_ready), 32'(exp_rdy));
      if (push) exp_q.push_back({ec, ed});
   endtask

   // Output monitor: compares every completed output handshake with the queue.
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (bus4.out_valid && bus4.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got data %h ch %0d, expected none", bus4.out_data, bus4.out_ch);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(bus4.out_data), 32'(e[7:0]));
               chk("out_ch", 32'(bus4.out_ch), 32'(e[9:8]));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      drive(4'hF, 32'h44332211, 1'b0, 2'd0, 1'b1);
      bus3.in_valid  = 3'b000;
      bus3.in_data   = 24'h332211;
      bus3.out_ready = 1'b1;
      mode3          = 1'b0;
      sel3           = 2'd0;
`ifdef STREAM_MUX_HOLD_EN
      bus3.in_last   = 3'b111;
`endif

      // reset state
      @(negedge clk);
      #2;
      chk("rst_in_ready", 32'(bus4.in_ready), 32'h0);
      chk("rst_out_valid", 32'(bus4.out_valid), 32'h0);
      chk("rst_out_data", 32'(bus4.out_data), 32'h0);
      chk("rst_out_ch", 32'(bus4.out_ch), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'h0, 32'h0, 1'b0, 2'd0, 1'b1);

      // explicit select
      cyc("sel2", 4'hF, 32'h11A52233, 1'b0, 2'd2, 1'b1, 4'b0100, 1, 8'hA5, 2'd2);
      cyc("sel0", 4'hF, 32'h11A52233, 1'b0, 2'd0, 1'b1, 4'b0001, 1, 8'h33, 2'd0);
      cyc("idle1", 4'h0, 32'h0, 1'b0, 2'd0, 1'b1, 4'b0000, 0, 8'h0, 2'd0);

      // round-robin, all channels requesting
      for (int i = 0; i < 8; i++) begin
         logic [31:0] dd;
         dd = 32'h44332211;
         cyc("rr_all", 4'hF, dd, 1'b1, 2'd0, 1'b1, 4'(1 << (i % 4)), 1,
             dd[(i%4)*8 +: 8], 2'(i % 4));
      end
      cyc("idle2", 4'h0, 32'h0, 1'b1, 2'd0, 1'b1, 4'b0000, 0, 8'h0, 2'd0);

      // round-robin, sparse requests
      cyc("rr_sp1", 4'b1010, 32'h44332211, 1'b1, 2'd0, 1'b1, 4'b0010, 1, 8'h22, 2'd1);
      cyc("rr_sp2", 4'b1010, 32'h44332211, 1'b1, 2'd0, 1'b1, 4'b1000, 1, 8'h44, 2'd3);
      cyc("rr_sp3", 4'b0001, 32'h44332211, 1'b1, 2'd0, 1'b1, 4'b0001, 1, 8'h11, 2'd0);
      cyc("idle3", 4'h0, 32'h0, 1'b1, 2'd0, 1'b1, 4'b0000, 0, 8'h0, 2'd0);

      // explicit select of a channel that is not valid
      cyc("sel_novalid", 4'b1011, 32'h44332211, 1'b0, 2'd2, 1'b1, 4'b0000, 0, 8'h0, 2'd0);

      // backpressure
      cyc("bp_load", 4'b0010, 32'h00003C00, 1'b0, 2'd1, 1'b0, 4'b0010, 1, 8'h3C, 2'd1);
      for (int i = 0; i < 5; i++) begin
         cyc("bp_hold_rdy", 4'hF, 32'h00007700, (i == 2), (i == 2) ? 2'd3 : 2'd1,
             1'b0, 4'b0000, 0, 8'h0, 2'd0);
         chk("bp_hold_data", 32'(bus4.out_data), 32'h3C);
         chk("bp_hold_valid", 32'(bus4.out_valid), 32'h1);
      end
      cyc("bp_release", 4'b0010, 32'h00007700, 1'b0, 2'd1, 1'b1, 4'b0010, 1, 8'h77, 2'd1);
      cyc("idle4", 4'h0, 32'h0, 1'b0, 2'd0, 1'b1, 4'b0000, 0, 8'h0, 2'd0);

      // reset with a beat held in the output register (rr_ptr=1 here)
      cyc("mid_load", 4'b0100, 32'h005A0000, 1'b1, 2'd0, 1'b0, 4'b0100, 0, 8'h0, 2'd0);
      cyc("mid_hold", 4'h0, 32'h0, 1'b1, 2'd0, 1'b0, 4'b0000, 0, 8'h0, 2'd0);
      chk("mid_valid", 32'(bus4.out_valid), 32'h1);
      chk("mid_data", 32'(bus4.out_data), 32'h5A);
      chk("mid_ch", 32'(bus4.out_ch), 32'h2);
      @(negedge clk);
      rst_n = 1'b0;
      drive(4'hF, 32'h44332211, 1'b1, 2'd0, 1'b1);
      #2;
      chk("mid_rst_in_ready", 32'(bus4.in_ready), 32'h0);
      chk("mid_rst_valid", 32'(bus4.out_valid), 32'h0);
      chk("mid_rst_data", 32'(bus4.out_data), 32'h0);
      chk("mid_rst_ch", 32'(bus4.out_ch), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'hF, 32'h44332211, 1'b1, 2'd0, 1'b1);
      #2;
      chk("rr_ptr_after_rst", 32'(bus4.in_ready), 32'b0001);
      exp_q.push_back({2'd0, 8'h11});
      cyc("idle5", 4'h0, 32'h0, 1'b1, 2'd0, 1'b1, 4'b0000, 0, 8'h0, 2'd0);

`ifdef STREAM_MUX_HOLD_EN
      // multi-beat lock on ch1 (rr_ptr=1), ch0 and ch2 also requesting
      hold_last = 4'b0000;
      cyc("hold_b1", 4'b0111, 32'h00C2B1A0, 1'b1, 2'd0, 1'b1, 4'b0010, 1, 8'hB1, 2'd1);
      cyc("hold_b2", 4'b0111, 32'h00C2B2A0, 1'b0, 2'd0, 1'b1, 4'b0010, 1, 8'hB2, 2'd1);
      hold_last = 4'b0010;
      cyc("hold_b3", 4'b0111, 32'h00C2B3A0, 1'b1, 2'd0, 1'b1, 4'b0010, 1, 8'hB3, 2'd1);
      hold_last = 4'hF;
      cyc("hold_next", 4'b0111, 32'h00C2B3A0, 1'b1, 2'd0, 1'b1, 4'b0100, 1, 8'hC2, 2'd2);
      cyc("idle6", 4'h0, 32'h0, 1'b1, 2'd0, 1'b1, 4'b0000, 0, 8'h0, 2'd0);
`endif

      // NUM_CH=3: sel=3 is out of range
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus3.in_valid = 3'b111;
         sel3 = 2'd3;
         #2;
         chk("sel_oob_ready", 32'(bus3.in_ready), 32'h0);
         chk("sel_oob_valid", 32'(bus3.out_valid), 32'h0);
      end
      @(negedge clk);
      sel3 = 2'd2;
      #2;
      chk("n3_sel2_ready", 32'(bus3.in_ready), 32'b100);
      @(negedge clk);
      bus3.in_valid = 3'b000;
      #2;
      chk("n3_out_valid", 32'(bus3.out_valid), 32'h1);
      chk("n3_out_data", 32'(bus3.out_data), 32'h33);
      chk("n3_out_ch", 32'(bus3.out_ch), 32'h2);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_mux_n_to_one.md
Name: stream_mux_n_to_one

Overview:
- Parametrised successor to the fixed 8-bit 2:1 selector: NUM_CH channels of WIDTH bits each, merged onto one registered output stream with valid/ready handshakes.
- Two modes, selected at run time:
  - explicit select, the classic mux;
  - round-robin arbitration.
- Sits between the operand sources and the multiplier datapath; also reused wherever several producers share one consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_CH), select/index width (derived localparam, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready (one-hot or zero)
- mode  input  1  0 = explicit select, 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- out_data  output  WIDTH  registered data
- out_ch  output  SEL_W  channel index of the held out_data
- out_valid  output  1  output register full
- out_ready  input  1  consumer ready

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - On reset: out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready is all-zero while rst_n=0.
  - Reset mid-transfer discards held data; no handshake completes in that cycle.
- Output register, two states:
  - EMPTY (out_valid=0), FULL (out_valid=1).
  - load_en = !out_valid || out_ready. This gives full throughput: one transfer per cycle when out_ready is held high.
- Grant, combinational, computed every cycle:
  - mode=0: grant = sel, valid only if sel < NUM_CH and in_valid[sel]=1.
  - mode=1: grant = first channel with in_valid set, searching from rr_ptr upward with wrap to 0.
  - No requesting channel: no grant.
- Handshakes:
  - in_ready[g] = load_en && grant valid; all other bits are 0.
  - Input transfer occurs when in_valid[g] && in_ready[g].
  - Output transfer occurs when out_valid && out_ready.
- Latency: 1 cycle from accepted input to out_valid.
- Transitions:
  - EMPTY→FULL on input transfer.
  - FULL→FULL when output and input transfer in the same cycle; the register is reloaded.
  - FULL→EMPTY when output transfer occurs with no input transfer.
  - FULL with out_ready=0: out_data and out_ch stay stable; all in_ready=0.
- rr_ptr:
  - Updates only on an input transfer in mode=1, to (grant+1) mod NUM_CH.
  - Unchanged in mode=0.
- Boundaries:
  - sel >= NUM_CH (non-power-of-2 NUM_CH): no grant and no transfer.
  - mode or sel change is sampled each cycle; data already in the output register is unaffected.
  - All channels valid in mode=1: strict rotation, no channel starved.
  - NUM_CH=2, mode=0 reproduces legacy 2:1 selection, registered.
- Width rule: data passes bit-exact; no sign extension or truncation.

Optional Feature:
- Macro: STREAM_MUX_HOLD_EN.
- When defined:
  - Adds input port in_last [NUM_CH].
  - Once a channel is granted, the grant is locked to it until a transfer with in_last=1. This keeps multi-beat operands contiguous.
  - mode/sel changes are ignored while locked.
  - Reset clears the lock.
- When undefined: no in_last port, and arbitration is per beat.

Decomposition:
- Shared package stream_mux_pkg holds:
  - the mode encoding constants MODE_SEL=1'b0 and MODE_RR=1'b1;
  - the state typedef {ST_EMPTY, ST_FULL}.
- One natural sub-module: rr_arbiter_n.
  - NUM_CH request vector plus pointer in; one-hot grant, index and grant_valid out.
  - Purely combinational; rr_ptr stays in the parent.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 → out_valid=0, out_data=0, in_ready=0 the same cycle; rr_ptr=0 after release.
- Explicit mode: mode=0, sel=2, ch2 data=8'hA5, others valid, out_ready=1 → in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2.
- Round-robin: mode=1, all four valid, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3, one beat per cycle.
- Backpressure: out_ready=0 for 5 cycles after a load with 8'h3C → out_data held at 8'h3C, in_ready=0; then out_ready=1 → next beat loads the same cycle.
- Invalid select: NUM_CH=3, sel=3, all valid → no in_ready asserted and out_valid stays 0.
- STREAM_MUX_HOLD_EN: ch1 sends 3 beats with in_last on beat 3 while ch0 and ch2 are valid → out_ch=1,1,1 and then 2.
